// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - shared constants and types for the pipeline hazard unit
package hazard_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int unsigned CNT_W             = 4;
    localparam logic [3:0]  MEM_TIMEOUT_LIMIT = 4'd15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - per-operand Execute-stage forward select
// Register 0 is hard-wired, so it never forwards; the younger M result beats W.
module hazard_fwd_sel
    import hazard_unit_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] writereg_m,
    input  logic [4:0] writereg_w,
    input  logic       regwrite_m,
    input  logic       regwrite_w,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if ((src != 5'd0) && regwrite_m && (src == writereg_m)) begin
            sel = FWD_MEM;
        end else if ((src != 5'd0) && regwrite_w && (src == writereg_w)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall/flush/forward control with a memory-wait FSM
// M/W shadow state tracks the in-flight writers; WAIT freezes F..M while memory is busy.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic       branchD,
    input  logic       regwriteE,
    input  logic       memtoregE,
    input  logic       memwriteE,
    input  logic       mem_ready,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushE,
    output logic       flushW,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       mem_timeout
);

    mem_state_e       state_q, state_d;
    logic [4:0]       writereg_m_q, writereg_m_d;
    logic [4:0]       writereg_w_q, writereg_w_d;
    logic             regwrite_m_q, regwrite_m_d;
    logic             memtoreg_m_q, memtoreg_m_d;
    logic             memaccess_m_q, memaccess_m_d;
    logic             regwrite_w_q, regwrite_w_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic             in_wait;
    logic             lwstall;
    logic             branchstall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (memaccess_m_q && !mem_ready) state_d = ST_WAIT;
            ST_WAIT: if (mem_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_wait = (state_q == ST_WAIT);

    always_comb begin
        writereg_m_d  = writereg_m_q;
        regwrite_m_d  = regwrite_m_q;
        memtoreg_m_d  = memtoreg_m_q;
        memaccess_m_d = memaccess_m_q;
        writereg_w_d  = writereg_m_q;
        regwrite_w_d  = regwrite_m_q;
        if (in_wait) begin
            regwrite_w_d = 1'b0;
        end else begin
            writereg_m_d  = writeregE;
            regwrite_m_d  = regwriteE;
            memtoreg_m_d  = memtoregE;
            memaccess_m_d = memtoregE | memwriteE;
        end
    end

    // Counter only advances while WAIT persists, so a completing cycle never trips the timeout.
    always_comb begin
        wait_cnt_d = '0;
        if (in_wait && (state_d == ST_WAIT)) begin
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
        mem_timeout_d = mem_timeout_q | (wait_cnt_d == MEM_TIMEOUT_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            writereg_m_q  <= '0;
            regwrite_m_q  <= 1'b0;
            memtoreg_m_q  <= 1'b0;
            memaccess_m_q <= 1'b0;
            writereg_w_q  <= '0;
            regwrite_w_q  <= 1'b0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            writereg_m_q  <= writereg_m_d;
            regwrite_m_q  <= regwrite_m_d;
            memtoreg_m_q  <= memtoreg_m_d;
            memaccess_m_q <= memaccess_m_d;
            writereg_w_q  <= writereg_w_d;
            regwrite_w_q  <= regwrite_w_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    hazard_fwd_sel u_fwd_a (
        .src        (rsE),
        .writereg_m (writereg_m_q),
        .writereg_w (writereg_w_q),
        .regwrite_m (regwrite_m_q),
        .regwrite_w (regwrite_w_q),
        .sel        (forwardAE)
    );

    hazard_fwd_sel u_fwd_b (
        .src        (rtE),
        .writereg_m (writereg_m_q),
        .writereg_w (writereg_w_q),
        .regwrite_m (regwrite_m_q),
        .regwrite_w (regwrite_w_q),
        .sel        (forwardBE)
    );

    assign forwardAD = (rsD != 5'd0) && regwrite_m_q && (rsD == writereg_m_q);
    assign forwardBD = (rtD != 5'd0) && regwrite_m_q && (rtD == writereg_m_q);

    assign lwstall     = memtoregE && ((rtE == rsD) || (rtE == rtD));
    assign branchstall = branchD &&
                         ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                          (memtoreg_m_q && ((writereg_m_q == rsD) || (writereg_m_q == rtD))));

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        if (in_wait) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else begin
            stallF = lwstall | branchstall;
            stallD = lwstall | branchstall;
            flushE = lwstall | branchstall;
        end
    end

    assign mem_timeout = mem_timeout_q;

endmodule
